// File: rtl/ver_tim_pkg.sv
// rtl/ver_tim_pkg.sv - shared PONG timing constants and line-count helpers
// Purpose: line/pixel totals, vertical blank/sync boundaries and counter width
//          shared by hor_tim, ver_tim and the video mixer.
// Ports:   none (package).
package ver_tim_pkg;

  localparam int CNT_W        = 9;
  localparam int H_TOTAL      = 455;
  localparam int V_TOTAL      = 262;
  localparam int V_BLANK_END  = 16;
  localparam int V_SYNC_START = 4;
  localparam int V_SYNC_END   = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  // True when lo <= v < hi, evaluated in 32-bit signed space so any
  // parameter value compares cleanly against the 9-bit count.
  function automatic logic in_range(input cnt_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/ver_tim_if.sv
// rtl/ver_tim_if.sv - vertical timer line-tick input and timing outputs
// Purpose: bundles hreset and the vertical timing outputs.
// Ports:   hreset (to timer), vcnt[8:0], v256, vreset, vblank, vsync,
//          frame_cnt[7:0] (only with VER_TIM_FRAME_CNT_EN).
// Modports: master = ver_tim side, slave = horizontal timer / consumers.
interface ver_tim_if;
  import ver_tim_pkg::*;

  logic hreset;
  cnt_t vcnt;
  logic v256;
  logic vreset;
  logic vblank;
  logic vsync;
`ifdef VER_TIM_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  modport master (
    input  hreset,
    output vcnt, v256, vreset, vblank, vsync
`ifdef VER_TIM_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output hreset,
    input  vcnt, v256, vreset, vblank, vsync
`ifdef VER_TIM_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/ver_tim_rise_det.sv
// rtl/ver_tim_rise_det.sv - one-flop rising-edge detector
// Purpose: emits a one-clk pulse on the rising edge of a level input.
// Ports:   clk, rst (sync, active-high), din (level), pulse (din & ~din_q).
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic din_q;
  logic din_d;

  always_comb begin
    din_d = din;
  end

  // During reset the flop loads the live input rather than 0: a level that is
  // already high when reset releases must not be mistaken for a fresh edge.
  // With the input low during reset this leaves the flop cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= din;
    end else begin
      din_q <= din_d;
    end
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/ver_tim.sv
// rtl/ver_tim.sv - vertical timing generator for the PONG video chain
// Purpose: counts scan lines on rising edges of hreset and produces vertical
//          reset, blank and sync plus the line count for playfield/score logic.
// Ports:   clk, reset (sync, active-high), bus (ver_tim_if.master):
//          hreset in; vcnt, v256, vreset, vblank, vsync out;
//          frame_cnt out only when VER_TIM_FRAME_CNT_EN is defined.
// Config:  VER_TIM_FRAME_CNT_EN adds an 8-bit wrapping frame counter.
module ver_tim
  import ver_tim_pkg::*;
#(
  parameter int VTOTAL      = V_TOTAL,
  parameter int VBLANK_END  = V_BLANK_END,
  parameter int VSYNC_START = V_SYNC_START,
  parameter int VSYNC_END   = V_SYNC_END
) (
  input logic       clk,
  input logic       reset,
  ver_tim_if.master bus
);

  logic tick;

  cnt_t vcnt_q, vcnt_d;
  logic vreset_q, vreset_d;
  logic vblank_q, vblank_d;
  logic vsync_q, vsync_d;
`ifdef VER_TIM_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;
`endif

  rise_det u_hreset_det (
    .clk   (clk),
    .rst   (reset),
    .din   (bus.hreset),
    .pulse (tick)
  );

  always_comb begin
    vcnt_d   = vcnt_q;
    vreset_d = 1'b0;
`ifdef VER_TIM_FRAME_CNT_EN
    frame_cnt_d = frame_cnt_q;
`endif
    if (tick) begin
      // >= rather than == so an out-of-range count recovers on the next line.
      if (int'(vcnt_q) >= VTOTAL - 1) begin
        vcnt_d   = '0;
        vreset_d = 1'b1;
`ifdef VER_TIM_FRAME_CNT_EN
        frame_cnt_d = frame_cnt_q + 8'd1;
`endif
      end else begin
        vcnt_d = vcnt_q + cnt_t'(1);
      end
    end
    // Decoding the next count keeps blank/sync aligned with vcnt.
    vblank_d = in_range(vcnt_d, 0, VBLANK_END);
    vsync_d  = in_range(vcnt_d, VSYNC_START, VSYNC_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vcnt_q   <= '0;
      vreset_q <= 1'b0;
      vblank_q <= 1'b1;
      vsync_q  <= 1'b0;
`ifdef VER_TIM_FRAME_CNT_EN
      frame_cnt_q <= 8'd0;
`endif
    end else begin
      vcnt_q   <= vcnt_d;
      vreset_q <= vreset_d;
      vblank_q <= vblank_d;
      vsync_q  <= vsync_d;
`ifdef VER_TIM_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign bus.vcnt   = vcnt_q;
  assign bus.v256   = vcnt_q[CNT_W-1];
  assign bus.vreset = vreset_q;
  assign bus.vblank = vblank_q;
  assign bus.vsync  = vsync_q;
`ifdef VER_TIM_FRAME_CNT_EN
  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule
